// File: rtl/fetch_stage.sv
// Instruction-fetch stage: fetch PC, in-flight tag queue, prefetch FIFO and IF/ID register.
// Define FETCH_PERF_EN to build the perf_fetched/perf_bubbles counters; otherwise both read 0.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc_f;
  logic [31:0]   tag_mem [FIFO_DEPTH];
  logic [AW-1:0] tag_wr, tag_rd;
  logic [CW-1:0] outstanding, drop_cnt;
  logic [31:0]   pf_pc   [FIFO_DEPTH];
  logic [31:0]   pf_data [FIFO_DEPTH];
  logic [AW-1:0] pf_wr, pf_rd;
  logic [CW-1:0] pf_count;

  logic          fire, pop, push;
  logic [CW:0]   credit_used;
  logic [CW-1:0] outstanding_net;

  assign fire = imem_req_valid && imem_req_ready;
  assign pop  = (pf_count != '0) && !pc_src_e && !flush_d && !stall_d;
  // a response is kept only when it is not stale and the FIFO is not being cleared
  assign push = imem_rsp_valid && (drop_cnt == '0) && !pc_src_e;

  assign credit_used = {1'b0, outstanding} + {1'b0, pf_count} - {{CW{1'b0}}, pop};
  assign imem_req_valid = !reset && !stall_f && !pc_src_e && (credit_used < DEPTH_C);
  assign imem_req_addr  = pc_f;
  assign outstanding_net = outstanding - {{AW{1'b0}}, imem_rsp_valid};

  always_ff @(posedge clk) begin
    if (fire) tag_mem[tag_wr] <= pc_f;
    if (push) begin
      pf_pc[pf_wr]   <= tag_mem[tag_rd];
      pf_data[pf_wr] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f        <= RESET_PC;
      tag_wr      <= '0;
      tag_rd      <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      pf_wr       <= '0;
      pf_rd       <= '0;
      pf_count    <= '0;
    end else begin
      if (pc_src_e)  pc_f <= pc_target_e;
      else if (fire) pc_f <= pc_f + 32'd4;

      if (fire)           tag_wr <= tag_wr + 1'b1;
      if (imem_rsp_valid) tag_rd <= tag_rd + 1'b1;
      outstanding <= outstanding_net + {{AW{1'b0}}, fire};

      if (pc_src_e) begin
        drop_cnt <= outstanding_net;
        pf_wr    <= '0;
        pf_rd    <= '0;
        pf_count <= '0;
      end else begin
        if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        if (push) pf_wr <= pf_wr + 1'b1;
        if (pop)  pf_rd <= pf_rd + 1'b1;
        pf_count <= pf_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_d    <= NOP;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (flush_d) begin
      instr_d    <= NOP;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (!stall_d) begin
      if (pop) begin
        instr_d    <= pf_data[pf_rd];
        pc_d       <= pf_pc[pf_rd];
        pc_plus4_d <= pf_pc[pf_rd] + 32'd4;
        valid_d    <= 1'b1;
      end else begin
        instr_d    <= NOP;
        pc_d       <= '0;
        pc_plus4_d <= '0;
        valid_d    <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic        load_bubble;
  logic [31:0] perf_fetched_q, perf_bubbles_q;

  assign load_bubble = flush_d || (!stall_d && !pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      if (pop)         perf_fetched_q <= perf_fetched_q + 32'd1;
      if (load_bubble) perf_bubbles_q <= perf_bubbles_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`else
  assign perf_fetched = '0;
  assign perf_bubbles = '0;
`endif
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined RISC-V core. It sits directly upstream of the decode controlpath. It keeps the fetch PC and issues requests to instruction memory over a valid/ready handshake. Responses are buffered in a small prefetch FIFO, and the IF/ID register that drives decode (`op`/`funct3`/`funct7` are slices of `instr_d`) is loaded from that FIFO. The stage consumes `pc_src_e` and the branch/jump target from execute, plus the stall/flush controls from the hazard unit.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `FIFO_DEPTH`, default 2: prefetch entries; power of two, ≥2.
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high reset.
- `stall_f`  in  1: freeze the fetch PC and issue no new request.
- `stall_d`  in  1: hold the IF/ID register.
- `flush_d`  in  1: load a bubble into IF/ID.
- `pc_src_e`  in  1: redirect fetch (taken branch or jump).
- `pc_target_e`  in  32: redirect address.
- `imem_req_valid`  out  1: request valid.
- `imem_req_ready`  in  1: memory accepts the request.
- `imem_req_addr`  out  32: word-aligned fetch address.
- `imem_rsp_valid`  in  1: response valid. Responses come back in order, at least 1 cycle after acceptance, and cannot be back-pressured.
- `imem_rsp_data`  in  32: instruction word.
- `instr_d`  out  32: decode-stage instruction.
- `pc_d`  out  32: decode-stage PC.
- `pc_plus4_d`  out  32: `pc_d`+4.
- `valid_d`  out  1: `instr_d` is a real fetched instruction.
- `perf_fetched`, `perf_bubbles`  out  32 each: performance counters (see Configuration).

## Operation
- **Fetch PC (`pc_f`)**
  - A request fires when `imem_req_valid && imem_req_ready`.
  - On a fire, `pc_f` advances by 4 and the PC is pushed into an internal in-flight tag queue of depth `FIFO_DEPTH`.
- **Credit rule**
  - `imem_req_valid = !reset && !stall_f && !pc_src_e && (outstanding + fifo_count - pop) < FIFO_DEPTH`.
  - `pop` is the decode-side pop in the current cycle.
  - `imem_req_addr = pc_f`. Address and valid stay stable while waiting for ready; a redirect may withdraw them.
- **Response path**
  - Each `imem_rsp_valid` pushes {tag PC, data} into the prefetch FIFO and decrements `outstanding`.
  - The credit rule guarantees the FIFO never overflows.
- **Redirect (`pc_src_e`=1)**
  - `pc_f` ← `pc_target_e` and the prefetch FIFO is cleared.
  - `drop_cnt` ← current `outstanding` (net of any response arriving this cycle). The next `drop_cnt` responses are discarded, each one decrementing both `drop_cnt` and `outstanding`.
  - No request is issued in the redirect cycle.
  - The redirect overrides `stall_f`.
- **IF/ID register** (priority order)
  1. `flush_d`: bubble; `valid_d`=0, `instr_d`=32'h0000_0013 (NOP), `pc_d`/`pc_plus4_d`=0.
  2. `stall_d`: hold all fields.
  3. FIFO non-empty and not redirecting: pop the head; `valid_d`=1.
  4. Otherwise: bubble.
- **Redirect with no flush**: if `pc_src_e` is asserted without `flush_d`, the FIFO head is still discarded and IF/ID takes a bubble.

## Timing
- **Reset values**: `pc_f`=`RESET_PC`; FIFO, `outstanding` and `drop_cnt` are 0; `imem_req_valid`=0; `valid_d`=0; `instr_d`=NOP; `pc_d`=`pc_plus4_d`=0; perf counters 0.
- **First request** fires in the first cycle after `reset` deasserts.
- **Latency**: a request accepted in cycle N with its response in N+1 appears on `instr_d`/`valid_d` in cycle N+2. There is no FIFO bypass.
- **Throughput**: with `FIFO_DEPTH`=2, 1-cycle memory latency and no stalls, the stage delivers one instruction per cycle.
- **Redirect timing**: `pc_src_e` in cycle N gives a request to `pc_target_e` in N+1, and that instruction reaches decode in N+3 at the earliest.
- **Wrap-around**: `pc_f` wraps modulo 2^32 from 32'hFFFF_FFFC to 0.
- **Reset mid-operation** clears all state immediately (asynchronous). Responses belonging to pre-reset requests are the memory's responsibility and must not be sent.

## Configuration
- `FETCH_PERF_EN` defined:
  - `perf_fetched` increments on every pop into IF/ID with `valid_d`=1.
  - `perf_bubbles` increments on every cycle IF/ID loads a bubble, including flushes.
  - Both wrap modulo 2^32.
- Undefined: both ports are tied to 0 and no counter flops exist.

## Test plan
- **Reset/start**: `RESET_PC`=0x100, memory latency 1, always ready → first request at 0x100, then 0x104, 0x108. `instr_d` matches memory, with `pc_d`=0x100 two cycles after the first fire, then one per cycle.
- **Back-pressure**: `imem_req_ready`=0 for 3 cycles → `imem_req_addr` stays 0x104 throughout and no duplicate response appears. Fetch resumes in order.
- **Redirect with 2 in flight**: memory latency 3, `pc_src_e` pulsed with target 0x200 → the 2 stale responses are discarded. The next `valid_d` has `pc_d`=0x200; 0x108 and 0x10C never reach decode.
- **Stall**: `stall_d`=1 and `stall_f`=1 for 2 cycles → `instr_d`/`pc_d` held, no request issued, no overflow. The sequence resumes without loss or duplication.
- **Simultaneous events**: `flush_d` and `stall_d` in the same cycle → bubble (NOP, `valid_d`=0). `pc_src_e` and `stall_f` together → `pc_f`=target.
- **Perf counters** (`FETCH_PERF_EN`): 10 instructions plus 1 redirect-induced flush → `perf_fetched`=10 and `perf_bubbles`≥1, matching a reference count. With the macro undefined, both ports read 0.
